// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle control FSM for the MIPS-subset datapath.
// Steps every instruction through FETCH/DECODE/EXEC/MEM/WB, waits on memory
// ready handshakes and traps stuck memory accesses with a watchdog.
// Optional feature macro: SEQ_PERF_CNT_EN adds cycle/retired-instruction counters.
module multicycle_sequencer #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       aluZero,
   input  logic       imemReady,
   input  logic       dmemReady,
   input  logic       resume,
   output logic       imemReq,
   output logic       irWrite,
   output logic       dmemRead,
   output logic       dmemWrite,
   output logic       regWrite,
   output logic       pcWrite,
   output logic [1:0] nextPcSel,
   output logic [4:0] aluControl,
   output logic       aluSrc,
   output logic [1:0] regDst,
   output logic [1:0] memToReg,
   output logic       retire,
   output logic       halted,
   output logic       memFault
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycleCnt,
   output logic [CNT_W-1:0] instretCnt
`endif
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   typedef enum logic [3:0] {
      C_NOP,
      C_ADDU,
      C_SUBU,
      C_ORI,
      C_LUI,
      C_LW,
      C_SW,
      C_BEQ,
      C_J,
      C_JAL,
      C_JR,
      C_SYSCALL
   } iclass_t;

   localparam logic [4:0]  ALU_ADD = 5'b00000;
   localparam logic [4:0]  ALU_SUB = 5'b00001;
   localparam logic [4:0]  ALU_OR  = 5'b00010;
   localparam logic [4:0]  ALU_LUI = 5'b00011;
   localparam logic [15:0] WD_LAST = 16'(MEM_TIMEOUT - 1);

   // Reject parameter values the watchdog and counters cannot represent.
   if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 65535 || CNT_W < 1) begin : gBadConfig
      $error("multicycle_sequencer: MEM_TIMEOUT must be 1..65535 and CNT_W >= 1");
   end

   state_t      r_state;
   state_t      w_nextState;
   iclass_t     r_class;
   iclass_t     w_class;
   logic [15:0] r_wdCnt;
   logic        r_memFault;
   logic        w_waiting;
   logic        w_wdExpire;

   logic       w_imemReq;
   logic       w_irWrite;
   logic       w_dmemRead;
   logic       w_dmemWrite;
   logic       w_regWrite;
   logic       w_pcWrite;
   logic [1:0] w_nextPcSel;
   logic [4:0] w_aluControl;
   logic       w_aluSrc;
   logic [1:0] w_regDst;
   logic [1:0] w_memToReg;
   logic       w_halted;
   logic [4:0] w_clsAluControl;
   logic       w_clsAluSrc;

   // Classify the instruction currently held in IR; anything unrecognised becomes a NOP.
   always_comb begin
      w_class = C_NOP;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h21:   w_class = C_ADDU;
               6'h23:   w_class = C_SUBU;
               6'h08:   w_class = C_JR;
               6'h0C:   w_class = C_SYSCALL;
               default: w_class = C_NOP;
            endcase
         end
         6'h0D:   w_class = C_ORI;
         6'h0F:   w_class = C_LUI;
         6'h23:   w_class = C_LW;
         6'h2B:   w_class = C_SW;
         6'h04:   w_class = C_BEQ;
         6'h02:   w_class = C_J;
         6'h03:   w_class = C_JAL;
         default: w_class = C_NOP;
      endcase
   end

   // ALU operation for the latched class, held from EXEC through WB so addresses stay stable.
   always_comb begin
      w_clsAluControl = ALU_ADD;
      w_clsAluSrc     = 1'b0;
      case (r_class)
         C_SUBU:  w_clsAluControl = ALU_SUB;
         C_BEQ:   w_clsAluControl = ALU_SUB;
         C_ORI: begin
            w_clsAluControl = ALU_OR;
            w_clsAluSrc     = 1'b1;
         end
         C_LUI: begin
            w_clsAluControl = ALU_LUI;
            w_clsAluSrc     = 1'b1;
         end
         C_LW, C_SW: begin
            w_clsAluControl = ALU_ADD;
            w_clsAluSrc     = 1'b1;
         end
         default: w_clsAluControl = ALU_ADD;
      endcase
   end

   // Next-state and strobe decode; the watchdog overrides the next state when it expires.
   always_comb begin
      w_nextState  = r_state;
      w_imemReq    = 1'b0;
      w_irWrite    = 1'b0;
      w_dmemRead   = 1'b0;
      w_dmemWrite  = 1'b0;
      w_regWrite   = 1'b0;
      w_pcWrite    = 1'b0;
      w_nextPcSel  = 2'b00;
      w_aluControl = ALU_ADD;
      w_aluSrc     = 1'b0;
      w_regDst     = 2'b00;
      w_memToReg   = 2'b00;
      w_halted     = 1'b0;
      w_waiting    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_imemReq = 1'b1;
            if (imemReady) begin
               w_irWrite   = 1'b1;
               w_nextState = S_DECODE;
            end else begin
               w_waiting = 1'b1;
            end
         end
         S_DECODE: begin
            case (w_class)
               C_J: begin
                  w_pcWrite   = 1'b1;
                  w_nextPcSel = 2'b10;
                  w_nextState = S_FETCH;
               end
               C_JR: begin
                  w_pcWrite   = 1'b1;
                  w_nextPcSel = 2'b11;
                  w_nextState = S_FETCH;
               end
               C_JAL:     w_nextState = S_WB;
               C_SYSCALL: begin
                  w_pcWrite   = 1'b1;
                  w_nextState = S_HALT;
               end
               C_NOP: begin
                  w_pcWrite   = 1'b1;
                  w_nextState = S_FETCH;
               end
               default:   w_nextState = S_EXEC;
            endcase
         end
         S_EXEC: begin
            w_aluControl = w_clsAluControl;
            w_aluSrc     = w_clsAluSrc;
            case (r_class)
               C_LW, C_SW: w_nextState = S_MEM;
               C_BEQ: begin
                  w_pcWrite   = 1'b1;
                  w_nextPcSel = {1'b0, aluZero};
                  w_nextState = S_FETCH;
               end
               default:    w_nextState = S_WB;
            endcase
         end
         S_MEM: begin
            w_aluControl = w_clsAluControl;
            w_aluSrc     = w_clsAluSrc;
            if (r_class == C_LW) begin
               w_dmemRead = 1'b1;
            end else begin
               w_dmemWrite = 1'b1;
            end
            if (dmemReady) begin
               if (r_class == C_LW) begin
                  w_nextState = S_WB;
               end else begin
                  w_pcWrite   = 1'b1;
                  w_nextState = S_FETCH;
               end
            end else begin
               w_waiting = 1'b1;
            end
         end
         S_WB: begin
            w_aluControl = w_clsAluControl;
            w_aluSrc     = w_clsAluSrc;
            w_regWrite   = 1'b1;
            w_pcWrite    = 1'b1;
            w_nextState  = S_FETCH;
            case (r_class)
               C_ADDU, C_SUBU: w_regDst = 2'b01;
               C_LW:           w_memToReg = 2'b01;
               C_JAL: begin
                  w_regDst    = 2'b10;
                  w_memToReg  = 2'b10;
                  w_nextPcSel = 2'b10;
               end
               default:        w_regDst = 2'b00;
            endcase
         end
         S_HALT: begin
            w_halted = 1'b1;
            if (resume && !r_memFault) begin
               w_nextState = S_FETCH;
            end
         end
         default: w_nextState = S_FETCH;
      endcase
      w_wdExpire = w_waiting && (r_wdCnt == WD_LAST);
      if (w_wdExpire) begin
         w_nextState = S_HALT;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Latch the instruction class while IR is being decoded so later states do not depend on opcode.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_class <= C_NOP;
      end else if (r_state == S_DECODE) begin
         r_class <= w_class;
      end
   end

   // Watchdog: counts consecutive unanswered request cycles and raises a sticky fault at the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdCnt    <= 16'd0;
         r_memFault <= 1'b0;
      end else if (w_wdExpire) begin
         r_wdCnt    <= 16'd0;
         r_memFault <= 1'b1;
      end else if (w_waiting) begin
         r_wdCnt <= r_wdCnt + 16'd1;
      end else begin
         r_wdCnt <= 16'd0;
      end
   end

`ifdef SEQ_PERF_CNT_EN
   logic [CNT_W-1:0] r_cycleCnt;
   logic [CNT_W-1:0] r_instretCnt;

   // Performance counters: running cycles outside HALT and retired instructions, both wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cycleCnt   <= '0;
         r_instretCnt <= '0;
      end else begin
         if (r_state != S_HALT) begin
            r_cycleCnt <= r_cycleCnt + CNT_W'(1);
         end
         if (w_pcWrite) begin
            r_instretCnt <= r_instretCnt + CNT_W'(1);
         end
      end
   end

   assign cycleCnt   = rst ? '0 : r_cycleCnt;
   assign instretCnt = rst ? '0 : r_instretCnt;
`endif

   assign imemReq    = w_imemReq & ~rst;
   assign irWrite    = w_irWrite & ~rst;
   assign dmemRead   = w_dmemRead & ~rst;
   assign dmemWrite  = w_dmemWrite & ~rst;
   assign regWrite   = w_regWrite & ~rst;
   assign pcWrite    = w_pcWrite & ~rst;
   assign retire     = w_pcWrite & ~rst;
   assign nextPcSel  = rst ? 2'b00 : w_nextPcSel;
   assign aluControl = rst ? 5'b00000 : w_aluControl;
   assign aluSrc     = w_aluSrc & ~rst;
   assign regDst     = rst ? 2'b00 : w_regDst;
   assign memToReg   = rst ? 2'b00 : w_memToReg;
   assign halted     = w_halted & ~rst;
   assign memFault   = r_memFault & ~rst;

endmodule
